// File: rtl/pipeline_control_pkg.sv
// Shared types for the LC-3b pipeline stall/flush sequencer.
package pipeline_control_pkg;

    // Architectural register index (R0..R7).
    typedef logic [2:0] lc3b_reg;

    // MEM-stage D-mem access sequencing.
    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_IND2 = 2'd1,
        D_DONE = 2'd2
    } lc3b_dmem_state;

    // True when an ID-stage source that is actually read matches a destination.
    function automatic logic src_matches(input logic    use_src,
                                         input lc3b_reg src,
                                         input lc3b_reg dst);
        return use_src && (src == dst);
    endfunction

endpackage

// File: rtl/pipeline_control_dmem_sequencer.sv
// MEM-stage D-mem access sequencer, including the two-phase LDI/STI.
//
//  state  | meaning
//  -------+-----------------------------------------------------------------
//  D_IDLE | ready; issues phase 1 (or the only phase) of a MEM access
//  D_IND2 | pointer captured; issues phase 2 of LDI/STI via pointer reg
//  D_DONE | access finished but fetch still stalled; hold off re-issuing
module dmem_sequencer
    import pipeline_control_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic acc,
    input  logic mem_rd,
    input  logic mem_wr,
    input  logic mem_indirect,
    input  logic dmem_resp,
    input  logic if_stall,
    output logic dmem_read,
    output logic dmem_write,
    output logic ind_phase2,
    output logic load_ptr,
    output logic load_mdr,
    output logic mem_done
);

    lc3b_dmem_state state_q;
    lc3b_dmem_state state_d;
    logic           final_resp;

    // Next-state and request/capture outputs; everything forced low while in reset.
    always_comb begin
        state_d    = state_q;
        dmem_read  = 1'b0;
        dmem_write = 1'b0;
        ind_phase2 = 1'b0;
        load_ptr   = 1'b0;
        load_mdr   = 1'b0;
        mem_done   = 1'b0;
        final_resp = 1'b0;
        if (reset) begin
            state_d = D_IDLE;
        end else begin
            case (state_q)
                D_IDLE: begin
                    if (acc) begin
                        // Indirect phase 1 is always a pointer read, even for STI.
                        dmem_read  = mem_rd | mem_indirect;
                        dmem_write = mem_wr & ~mem_indirect;
                        if (dmem_resp) begin
                            if (mem_indirect) begin
                                load_ptr = 1'b1;
                                state_d  = D_IND2;
                            end else begin
                                final_resp = 1'b1;
                            end
                        end
                    end
                end
                D_IND2: begin
                    ind_phase2 = 1'b1;
                    dmem_read  = mem_rd;
                    dmem_write = mem_wr;
                    if (dmem_resp) begin
                        final_resp = 1'b1;
                        state_d    = D_IDLE;
                    end
                end
                D_DONE: begin
                    mem_done = 1'b1;
                    // In D_DONE the MEM side is satisfied, so freeze reduces to if_stall.
                    if (!if_stall) begin
                        state_d = D_IDLE;
                    end
                end
                default: state_d = D_IDLE;
            endcase
            if (final_resp) begin
                load_mdr = mem_rd;
                mem_done = 1'b1;
                // Park in D_DONE so a still-stalled fetch cannot re-trigger the access.
                state_d  = if_stall ? D_DONE : D_IDLE;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= D_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/pipeline_control.sv
// Central stall/flush sequencer for the 5-stage LC-3b pipeline.
module pipeline_control
    import pipeline_control_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             imem_resp,
    input  logic             mem_valid,
    input  logic             mem_rd,
    input  logic             mem_wr,
    input  logic             mem_indirect,
    input  logic             mem_br_taken,
    input  logic             dmem_resp,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  lc3b_reg          ex_dest,
    input  logic             id_valid,
    input  lc3b_reg          id_sr1,
    input  lc3b_reg          id_sr2,
    input  logic             id_use_sr1,
    input  logic             id_use_sr2,
    output logic             load_pc,
    output logic             pc_sel_br,
    output logic             load_if_id,
    output logic             load_id_ex,
    output logic             load_ex_mem,
    output logic             load_mem_wb,
    output logic             bubble_id_ex,
    output logic             squash,
    output logic             dmem_read,
    output logic             dmem_write,
    output logic             ind_phase2,
    output logic             load_ptr,
    output logic             load_mdr,
    output logic [CNT_W-1:0] stall_count
);

    logic             acc;
    logic             if_stall;
    logic             mem_done;
    logic             mem_stall;
    logic             freeze;
    logic             lu;
    logic             br;
    logic [CNT_W-1:0] stall_count_q;
    logic [CNT_W-1:0] stall_count_d;

    assign acc      = mem_valid & (mem_rd | mem_wr);
    assign if_stall = ~imem_resp;

    dmem_sequencer u_dmem_seq (
        .clk          (clk),
        .reset        (reset),
        .acc          (acc),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_indirect (mem_indirect),
        .dmem_resp    (dmem_resp),
        .if_stall     (if_stall),
        .dmem_read    (dmem_read),
        .dmem_write   (dmem_write),
        .ind_phase2   (ind_phase2),
        .load_ptr     (load_ptr),
        .load_mdr     (load_mdr),
        .mem_done     (mem_done)
    );

    // Hazard detection and stage enables; priority reset > freeze > squash > load-use.
    always_comb begin
        mem_stall    = acc & ~mem_done;
        freeze       = mem_stall | if_stall;
        lu           = ex_valid & ex_is_load & id_valid &
                       (src_matches(id_use_sr1, id_sr1, ex_dest) |
                        src_matches(id_use_sr2, id_sr2, ex_dest));
        // A taken branch only redirects once the pipe is moving, so it is never lost.
        br           = ~freeze & mem_valid & mem_br_taken;
        load_pc      = 1'b0;
        pc_sel_br    = 1'b0;
        load_if_id   = 1'b0;
        load_id_ex   = 1'b0;
        load_ex_mem  = 1'b0;
        load_mem_wb  = 1'b0;
        bubble_id_ex = 1'b0;
        squash       = 1'b0;
        if (!reset) begin
            load_mem_wb  = ~freeze;
            load_ex_mem  = ~freeze;
            load_id_ex   = ~freeze;
            squash       = br;
            pc_sel_br    = br;
            bubble_id_ex = ~freeze & lu & ~br;
            load_if_id   = ~freeze & (~lu | br);
            load_pc      = ~freeze & (~lu | br);
        end
    end

    // Saturating frozen-cycle counter.
    always_comb begin
        stall_count_d = stall_count_q;
        if (freeze && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = reset ? '0 : stall_count_q;

endmodule

// File: tb/tb_pipeline_control.sv
// Self-checking bench for pipeline_control: directed scenarios plus a randomized
// run against a flag-based reference model of the stall/flush rules.
module tb_pipeline_control;

    localparam int unsigned CNT_W = 10;
    localparam int          CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             imem_resp;
    logic             mem_valid, mem_rd, mem_wr, mem_indirect, mem_br_taken;
    logic             dmem_resp;
    logic             ex_valid, ex_is_load;
    logic [2:0]       ex_dest;
    logic             id_valid;
    logic [2:0]       id_sr1, id_sr2;
    logic             id_use_sr1, id_use_sr2;
    logic             load_pc, pc_sel_br, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic             bubble_id_ex, squash;
    logic             dmem_read, dmem_write, ind_phase2, load_ptr, load_mdr;
    logic [CNT_W-1:0] stall_count;
    logic [12:0]      outs;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign outs = {load_pc, pc_sel_br, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                   bubble_id_ex, squash, dmem_read, dmem_write, ind_phase2, load_ptr, load_mdr};

    pipeline_control #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_resp    (imem_resp),
        .mem_valid    (mem_valid),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_indirect (mem_indirect),
        .mem_br_taken (mem_br_taken),
        .dmem_resp    (dmem_resp),
        .ex_valid     (ex_valid),
        .ex_is_load   (ex_is_load),
        .ex_dest      (ex_dest),
        .id_valid     (id_valid),
        .id_sr1       (id_sr1),
        .id_sr2       (id_sr2),
        .id_use_sr1   (id_use_sr1),
        .id_use_sr2   (id_use_sr2),
        .load_pc      (load_pc),
        .pc_sel_br    (pc_sel_br),
        .load_if_id   (load_if_id),
        .load_id_ex   (load_id_ex),
        .load_ex_mem  (load_ex_mem),
        .load_mem_wb  (load_mem_wb),
        .bubble_id_ex (bubble_id_ex),
        .squash       (squash),
        .dmem_read    (dmem_read),
        .dmem_write   (dmem_write),
        .ind_phase2   (ind_phase2),
        .load_ptr     (load_ptr),
        .load_mdr     (load_mdr),
        .stall_count  (stall_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset        = 1'b0;
        imem_resp    = 1'b1;
        mem_valid    = 1'b0;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        mem_indirect = 1'b0;
        mem_br_taken = 1'b0;
        dmem_resp    = 1'b0;
        ex_valid     = 1'b0;
        ex_is_load   = 1'b0;
        ex_dest      = 3'd0;
        id_valid     = 1'b0;
        id_sr1       = 3'd0;
        id_sr2       = 3'd0;
        id_use_sr1   = 1'b0;
        id_use_sr2   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        imem_resp    = 1'b0;
        mem_valid    = 1'b1;
        mem_rd       = 1'b1;
        mem_indirect = 1'b1;
        mem_br_taken = 1'b1;
        dmem_resp    = 1'b1;
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_dest = 3'd2;
        id_valid = 1'b1; id_sr1 = 3'd2; id_use_sr1 = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (outs !== 13'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want %b", outs, 13'd0);
        end
        n_cmp++;
        if (stall_count !== '0) begin
            n_err++;
            $display("FAIL reset_count: got %0d want 0", stall_count);
        end
        step();
        idle_inputs();
        @(negedge clk);
        n_cmp++;
        if (stall_count !== '0 || outs !== 13'b1011110000000) begin
            n_err++;
            $display("FAIL post_reset_idle: outs %b cnt %0d want outs %b cnt 0",
                     outs, stall_count, 13'b1011110000000);
        end
        step();
    endtask

    // LDR with response on the third cycle, fetch not stalled.
    task automatic test_ldr();
        logic [3:0] got, exp;
        do_reset();
        mem_valid = 1'b1;
        mem_rd    = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            dmem_resp = (c == 3);
            @(negedge clk);
            got = {dmem_read, dmem_write, load_mdr, load_ex_mem};
            exp = {1'b1, 1'b0, (c == 3), (c == 3)};
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL ldr_cycle%0d: got rd/wr/mdr/lex=%b want %b", c, got, exp);
            end
            step();
        end
        idle_inputs();
        @(negedge clk);
        n_cmp++;
        if (stall_count !== 10'd2 || dmem_read !== 1'b0) begin
            n_err++;
            $display("FAIL ldr_count: cnt %0d rd %b want cnt 2 rd 0", stall_count, dmem_read);
        end
        step();
    endtask

    // LDI / STI: pointer read, one wait cycle, then the phase-2 access.
    task automatic test_indirect(input logic is_store);
        logic [5:0] got;
        logic [5:0] exp [3];
        logic       resp [3];
        // {read, write, load_ptr, ind_phase2, load_mdr, load_ex_mem}
        exp[0] = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        exp[1] = {~is_store, is_store, 1'b0, 1'b1, 1'b0, 1'b0};
        exp[2] = {~is_store, is_store, 1'b0, 1'b1, ~is_store, 1'b1};
        resp[0] = 1'b1; resp[1] = 1'b0; resp[2] = 1'b1;
        do_reset();
        mem_valid    = 1'b1;
        mem_rd       = ~is_store;
        mem_wr       = is_store;
        mem_indirect = 1'b1;
        for (int c = 0; c < 3; c++) begin
            dmem_resp = resp[c];
            @(negedge clk);
            got = {dmem_read, dmem_write, load_ptr, ind_phase2, load_mdr, load_ex_mem};
            n_cmp++;
            if (got !== exp[c]) begin
                n_err++;
                $display("FAIL %s_cycle%0d: got %b want %b", is_store ? "sti" : "ldi", c, got, exp[c]);
            end
            step();
        end
        idle_inputs();
        @(negedge clk);
        n_cmp++;
        if (stall_count !== 10'd2 || ind_phase2 !== 1'b0) begin
            n_err++;
            $display("FAIL %s_after: cnt %0d ph2 %b want cnt 2 ph2 0",
                     is_store ? "sti" : "ldi", stall_count, ind_phase2);
        end
        step();
    endtask

    // STR completes while the fetch is still stalled: no re-issue, advance on imem_resp.
    task automatic test_str_done();
        logic [3:0] got;
        logic [3:0] exp [4];
        // {read, write, load_ex_mem, load_pc}
        exp[0] = 4'b0100; exp[1] = 4'b0000; exp[2] = 4'b0000; exp[3] = 4'b0011;
        do_reset();
        mem_valid = 1'b1;
        mem_wr    = 1'b1;
        for (int c = 0; c < 4; c++) begin
            dmem_resp = (c == 0);
            imem_resp = (c == 3);
            @(negedge clk);
            got = {dmem_read, dmem_write, load_ex_mem, load_pc};
            n_cmp++;
            if (got !== exp[c]) begin
                n_err++;
                $display("FAIL str_done_cycle%0d: got %b want %b", c, got, exp[c]);
            end
            step();
        end
        idle_inputs();
        @(negedge clk);
        n_cmp++;
        if (stall_count !== 10'd3) begin
            n_err++;
            $display("FAIL str_done_count: got %0d want 3", stall_count);
        end
        step();
    endtask

    task automatic test_load_use();
        logic [3:0] got;
        do_reset();
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_dest = 3'd3;
        id_valid = 1'b1; id_sr1 = 3'd3; id_use_sr1 = 1'b1;
        @(negedge clk);
        got = {bubble_id_ex, load_if_id, load_pc, load_id_ex};
        n_cmp++;
        if (got !== 4'b1001) begin
            n_err++;
            $display("FAIL lu_sr1: bub/ifid/pc/idex got %b want 1001", got);
        end
        step();
        id_sr1 = 3'd5; id_sr2 = 3'd3; id_use_sr2 = 1'b0;
        @(negedge clk);
        got = {bubble_id_ex, load_if_id, load_pc, load_id_ex};
        n_cmp++;
        if (got !== 4'b0111) begin
            n_err++;
            $display("FAIL lu_sr2_unused: got %b want 0111", got);
        end
        step();
        id_use_sr2 = 1'b1;
        @(negedge clk);
        got = {bubble_id_ex, load_if_id, load_pc, load_id_ex};
        n_cmp++;
        if (got !== 4'b1001) begin
            n_err++;
            $display("FAIL lu_sr2_used: got %b want 1001", got);
        end
        step();
        imem_resp = 1'b0;
        @(negedge clk);
        got = {bubble_id_ex, load_if_id, load_pc, load_id_ex};
        n_cmp++;
        if (got !== 4'b0000) begin
            n_err++;
            $display("FAIL lu_under_freeze: got %b want 0000", got);
        end
        step();
    endtask

    task automatic test_branch();
        logic [4:0] got;
        do_reset();
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_dest = 3'd1;
        id_valid = 1'b1; id_sr2 = 3'd1; id_use_sr2 = 1'b1;
        mem_valid = 1'b1; mem_br_taken = 1'b1;
        @(negedge clk);
        got = {squash, pc_sel_br, bubble_id_ex, load_pc, load_if_id};
        n_cmp++;
        if (got !== 5'b11011) begin
            n_err++;
            $display("FAIL br_over_lu: sq/sel/bub/pc/ifid got %b want 11011", got);
        end
        step();
        imem_resp = 1'b0;
        @(negedge clk);
        got = {squash, pc_sel_br, bubble_id_ex, load_pc, load_if_id};
        n_cmp++;
        if (got !== 5'b00000) begin
            n_err++;
            $display("FAIL br_waits_freeze: got %b want 00000", got);
        end
        step();
        imem_resp = 1'b1;
        @(negedge clk);
        got = {squash, pc_sel_br, bubble_id_ex, load_pc, load_if_id};
        n_cmp++;
        if (got !== 5'b11011) begin
            n_err++;
            $display("FAIL br_after_freeze: got %b want 11011", got);
        end
        step();
    endtask

    task automatic test_reset_mid_access();
        logic [3:0] got;
        do_reset();
        mem_valid = 1'b1; mem_rd = 1'b1; mem_indirect = 1'b1; dmem_resp = 1'b1;
        step();
        dmem_resp = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        got = {dmem_read, dmem_write, ind_phase2, load_ptr};
        n_cmp++;
        if (got !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_in_ind2: rd/wr/ph2/ptr got %b want 0000", got);
        end
        step();
        reset = 1'b0;
        @(negedge clk);
        got = {dmem_read, dmem_write, ind_phase2, load_ptr};
        n_cmp++;
        if (got !== 4'b1000) begin
            n_err++;
            $display("FAIL after_reset_phase1: got %b want 1000", got);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_saturate();
        int total;
        int want;
        total = (1 << CNT_W) + 5;
        do_reset();
        imem_resp = 1'b0;
        for (int i = 0; i <= total; i++) begin
            @(negedge clk);
            want = (i > CMAX) ? CMAX : i;
            if (i == CMAX - 1 || i == CMAX || i == CMAX + 1 || i == total) begin
                n_cmp++;
                if (stall_count !== want[CNT_W-1:0]) begin
                    n_err++;
                    $display("FAIL saturate_at_%0d: got %0d want %0d", i, stall_count, want);
                end
            end
            step();
        end
        idle_inputs();
    endtask

    // Randomized run: the model tracks "pointer held" and "finished, waiting for fetch".
    task automatic test_random(input int cycles);
        bit          m_ptr, m_hold;
        int          m_cnt;
        bit          acc, if_stall, fin, done, freeze, lu, br;
        bit          e_rd, e_wr, e_ph2, e_ptr, e_mdr;
        logic [12:0] exp;
        int          n_bad;
        do_reset();
        m_ptr = 0; m_hold = 0; m_cnt = 0; n_bad = 0;
        for (int c = 0; c < cycles; c++) begin
            reset        = ($urandom_range(0, 99) == 0);
            imem_resp    = ($urandom_range(0, 3) != 0);
            mem_valid    = ($urandom_range(0, 3) != 0);
            mem_rd       = 1'($urandom_range(0, 1));
            mem_wr       = 1'($urandom_range(0, 1));
            mem_indirect = ($urandom_range(0, 2) == 0);
            mem_br_taken = ($urandom_range(0, 3) == 0);
            dmem_resp    = ($urandom_range(0, 2) == 0);
            ex_valid     = 1'($urandom_range(0, 1));
            ex_is_load   = 1'($urandom_range(0, 1));
            ex_dest      = 3'($urandom_range(0, 3));
            id_valid     = 1'($urandom_range(0, 1));
            id_sr1       = 3'($urandom_range(0, 3));
            id_sr2       = 3'($urandom_range(0, 3));
            id_use_sr1   = 1'($urandom_range(0, 1));
            id_use_sr2   = 1'($urandom_range(0, 1));

            acc = mem_valid && (mem_rd || mem_wr);
            if_stall = !imem_resp;
            e_rd = 0; e_wr = 0; e_ph2 = 0; e_ptr = 0; e_mdr = 0; fin = 0;
            if (m_hold) begin
                done = 1;
            end else if (m_ptr) begin
                e_ph2 = 1; e_rd = mem_rd; e_wr = mem_wr;
                fin = dmem_resp;
                done = fin;
            end else begin
                if (acc) begin
                    e_rd = mem_rd || mem_indirect;
                    e_wr = mem_wr && !mem_indirect;
                    e_ptr = dmem_resp && mem_indirect;
                    fin = dmem_resp && !mem_indirect;
                end
                done = fin;
            end
            e_mdr  = fin && mem_rd;
            freeze = (acc && !done) || if_stall;
            lu = ex_valid && ex_is_load && id_valid &&
                 ((id_use_sr1 && id_sr1 == ex_dest) || (id_use_sr2 && id_sr2 == ex_dest));
            br = !freeze && mem_valid && mem_br_taken;
            exp = {!freeze && (!lu || br), br, !freeze && (!lu || br), !freeze, !freeze, !freeze,
                   !freeze && lu && !br, br, e_rd, e_wr, e_ph2, e_ptr, e_mdr};
            if (reset) exp = '0;

            @(negedge clk);
            n_cmp++;
            if (outs !== exp || stall_count !== (reset ? 0 : m_cnt[CNT_W-1:0])) begin
                n_err++;
                n_bad++;
                if (n_bad <= 10)
                    $display("FAIL random_cycle%0d: outs %b cnt %0d want outs %b cnt %0d",
                             c, outs, stall_count, exp, reset ? 0 : m_cnt);
            end

            if (reset) begin
                m_ptr = 0; m_hold = 0; m_cnt = 0;
            end else begin
                m_hold = (m_hold || fin) && if_stall;
                m_ptr  = (m_ptr && !dmem_resp) || e_ptr;
                if (freeze && m_cnt < CMAX) m_cnt++;
            end
            step();
        end
        idle_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        #1;
        test_reset();
        test_ldr();
        test_indirect(1'b0);
        test_indirect(1'b1);
        test_str_done();
        test_load_use();
        test_branch();
        test_reset_mid_access();
        test_saturate();
        test_random(3000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
